ped_infer_ctrl: RTL and testbench
=================================

Name: ped_infer_ctrl

Overview:
Command sequencer for the pedometer neural-network execution datapath (two-layer, three-node network followed by the activation block). It accepts instructions over a valid/ready handshake and decodes them as counter reset, count sample or weight write. It holds the six network weights stable during an inference, waits out the datapath pipeline latency, samples the step decision, and owns the saturating total-step counter.

Parameters:
DW, 10, width of samples, weights and step count
PIPE_LAT, 2, clock edges from ex_a/ex_b change to a valid ex_step (one per node layer); must be 1 or greater
STEP_MAX, 1023, saturation value of step_count; must be at most 2^DW-1

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_funct  in  3  0=reset counter, 1=count sample, 2=write weight, 3..7 illegal
cmd_a  in  DW  sample X (funct 1)
cmd_b  in  DW  sample Y (funct 1)
cmd_widx  in  3  weight index (funct 2): 0=theta1_1, 1=theta1_2, 2=theta2_1, 3=theta2_2, 4=alpha1, 5=alpha2
cmd_wdata  in  DW  weight value (funct 2)
ex_a, ex_b  out  DW  sample registers driving the datapath inputs
theta1_1, theta1_2, theta2_1, theta2_2, alpha1, alpha2  out  DW each  weight registers driving the datapath
ex_step  in  1  activation output from the datapath
step_count  out  DW  total steps
step_pulse  out  1  one-cycle pulse when step_count increments
sat  out  1  sticky flag: a step was detected while step_count was already STEP_MAX
err_illegal  out  1  one-cycle pulse on an accepted illegal command

Behaviour:
- Reset, synchronous, highest priority, allowed in any state:
  - state goes to IDLE.
  - ex_a, ex_b, all six weights and step_count go to 0.
  - step_pulse, sat and err_illegal go to 0.
  - cmd_ready is 1 in the first cycle after reset.
  - An inference in flight is abandoned and never counted.
- Handshake:
  - A command is accepted on a rising edge where cmd_valid and cmd_ready are both 1.
  - cmd_ready is a decode of state: 1 only in IDLE, and it does not depend on cmd_valid.
  - The command payload is sampled only at the accept edge.
- FSM states: IDLE, WAIT, CAPT.
  - IDLE, accept funct 0: step_count and sat cleared at the accept edge; stays IDLE.
  - IDLE, accept funct 2 with widx 0..5: the selected weight is loaded at the accept edge; stays IDLE.
  - IDLE, accept funct 2 with widx 6..7: no write; err_illegal pulses.
  - IDLE, accept funct 3..7: no state change; err_illegal pulses in the next cycle.
  - IDLE, accept funct 1: ex_a/ex_b load cmd_a/cmd_b; wait counter set to 1; go to WAIT.
  - WAIT: counter increments each edge; at the edge where counter == PIPE_LAT, go to CAPT.
  - CAPT, sampling edge, with ex_step == 1 and step_count < STEP_MAX: step_count increments by 1 and step_pulse is 1 for the following cycle.
  - CAPT, sampling edge, with ex_step == 1 and step_count == STEP_MAX: step_count holds and sat is set.
  - CAPT, sampling edge, with ex_step == 0: no count change.
  - CAPT always returns to IDLE at that edge.
- Timing, count sample accepted at edge E0:
  - ex_step is sampled at E0+PIPE_LAT+1.
  - step_count updates at that same edge.
  - cmd_ready is high again in the following cycle.
  - Peak throughput is one sample per PIPE_LAT+2 cycles.
- Weight and sample stability: weights and ex_a/ex_b change only on accepted IDLE commands, so they are constant throughout WAIT and CAPT.
- ex_step is ignored outside CAPT.
- Arithmetic: the counter is unsigned DW bits and never wraps.
- Back-to-back commands: a command held valid across CAPT→IDLE is accepted at the first edge where IDLE is asserted. No commands are lost or duplicated.

Test Plan:
- Reset then write widx 0..5 with 11,12,13,14,15,16 on consecutive cycles -> cmd_ready stays 1; weight outputs read 11..16 in order; err_illegal stays 0.
- PIPE_LAT=2, funct 1 accepted at edge E0 with cmd_a=100, cmd_b=200, ex_step forced 1 from E0+2 -> ex_a=100, ex_b=200 after E0; cmd_ready=0 for 3 cycles; step_count 0→1 at E0+3; step_pulse high one cycle.
- Sample with ex_step=0, then a weight write offered during WAIT -> step_count unchanged; weight write held off until IDLE; written value appears one edge after acceptance.
- Preload step_count to 1022, then three samples with ex_step=1 -> counts 1023, 1023, 1023; sat set on the second sample; step_pulse only on the first; funct 0 then clears the count to 0 and sat to 0.
- funct 5 accepted, and funct 2 with widx=7 accepted -> err_illegal pulses once for each; no weight, sample or count change.
- Assert rst one cycle during WAIT with ex_step=1 -> next cycle IDLE with step_count=0, weights=0 and cmd_ready=1; no step_pulse.

Source files
------------

// File: rtl/ped_infer_ctrl.sv
// ped_infer_ctrl
//   Command sequencer for the pedometer neural-network datapath. Accepts
//   reset-counter / count-sample / write-weight commands, holds the network
//   weights and sample registers stable during an inference, waits out the
//   datapath pipeline latency, samples the step decision and keeps a
//   saturating total-step counter.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
//   cmd_ready are both 1. cmd_ready is a pure decode of state (1 only in IDLE)
//   and never depends on cmd_valid. The payload is used only at that edge.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_funct                0=clear counter, 1=count sample, 2=write weight
//   cmd_a, cmd_b             sample X/Y for funct 1
//   cmd_widx, cmd_wdata      weight index/value for funct 2
//   ex_a, ex_b               sample registers to the datapath
//   theta*/alpha*            weight registers to the datapath
//   ex_step                  activation output from the datapath
//   step_count, step_pulse   total steps, one-cycle increment pulse
//   sat                      sticky: step seen while already at STEP_MAX
//   err_illegal              one-cycle pulse after an accepted illegal command
module ped_infer_ctrl #(
  parameter int DW       = 10,
  parameter int PIPE_LAT = 2,
  parameter int STEP_MAX = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_funct,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic [2:0]    cmd_widx,
  input  logic [DW-1:0] cmd_wdata,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] theta1_1,
  output logic [DW-1:0] theta1_2,
  output logic [DW-1:0] theta2_1,
  output logic [DW-1:0] theta2_2,
  output logic [DW-1:0] alpha1,
  output logic [DW-1:0] alpha2,
  input  logic          ex_step,
  output logic [DW-1:0] step_count,
  output logic          step_pulse,
  output logic          sat,
  output logic          err_illegal
);

  localparam int            CW         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT + 1) : 1;
  localparam logic [CW-1:0] LAT_V      = CW'(PIPE_LAT);
  localparam logic [DW-1:0] STEP_MAX_V = DW'(STEP_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;

  logic accept;
  logic is_clr;
  logic is_smp;
  logic is_wr;
  logic is_ill;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Command decode, qualified by accept. A weight write to index 6/7 is
  // treated as illegal so it produces the same error pulse as a bad funct.
  always_comb begin
    is_clr = 1'b0;
    is_smp = 1'b0;
    is_wr  = 1'b0;
    is_ill = 1'b0;
    if (accept) begin
      case (cmd_funct)
        3'd0:    is_clr = 1'b1;
        3'd1:    is_smp = 1'b1;
        3'd2:    begin
          if (cmd_widx <= 3'd5) is_wr  = 1'b1;
          else                  is_ill = 1'b1;
        end
        default: is_ill = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_smp) state_nxt = WAIT;
      WAIT:    if (wait_cnt == LAT_V) state_nxt = CAPT;
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      ex_a        <= '0;
      ex_b        <= '0;
      theta1_1    <= '0;
      theta1_2    <= '0;
      theta2_1    <= '0;
      theta2_2    <= '0;
      alpha1      <= '0;
      alpha2      <= '0;
      step_count  <= '0;
      step_pulse  <= 1'b0;
      sat         <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      state       <= state_nxt;
      step_pulse  <= 1'b0;
      err_illegal <= is_ill;

      if (is_clr) begin
        step_count <= '0;
        sat        <= 1'b0;
      end

      if (is_smp) begin
        ex_a     <= cmd_a;
        ex_b     <= cmd_b;
        wait_cnt <= CW'(1);
      end

      if (is_wr) begin
        case (cmd_widx)
          3'd0:    theta1_1 <= cmd_wdata;
          3'd1:    theta1_2 <= cmd_wdata;
          3'd2:    theta2_1 <= cmd_wdata;
          3'd3:    theta2_2 <= cmd_wdata;
          3'd4:    alpha1   <= cmd_wdata;
          3'd5:    alpha2   <= cmd_wdata;
          default: ;
        endcase
      end

      // Counter stops at PIPE_LAT since the FSM leaves WAIT on that edge.
      if (state == WAIT && wait_cnt != LAT_V) wait_cnt <= wait_cnt + CW'(1);

      // ex_step is only meaningful on the CAPT edge.
      if (state == CAPT && ex_step) begin
        if (step_count < STEP_MAX_V) begin
          step_count <= step_count + DW'(1);
          step_pulse <= 1'b1;
        end else begin
          sat <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ped_infer_ctrl.sv
module tb_ped_infer_ctrl;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_funct;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic [2:0]    cmd_widx;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [DW-1:0] theta1_1;
  logic [DW-1:0] theta1_2;
  logic [DW-1:0] theta2_1;
  logic [DW-1:0] theta2_2;
  logic [DW-1:0] alpha1;
  logic [DW-1:0] alpha2;
  logic          ex_step;
  logic [DW-1:0] step_count;
  logic          step_pulse;
  logic          sat;
  logic          err_illegal;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];

  ped_infer_ctrl #(.DW(DW), .PIPE_LAT(2), .STEP_MAX(1023)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct(cmd_funct),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_widx(cmd_widx), .cmd_wdata(cmd_wdata),
    .ex_a(ex_a), .ex_b(ex_b),
    .theta1_1(theta1_1), .theta1_2(theta1_2), .theta2_1(theta2_1),
    .theta2_2(theta2_2), .alpha1(alpha1), .alpha2(alpha2),
    .ex_step(ex_step), .step_count(step_count), .step_pulse(step_pulse),
    .sat(sat), .err_illegal(err_illegal)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Driver: presents a command at a negedge, waits (bounded) for cmd_ready,
  // then returns #1 after the accept edge with cmd_valid dropped.
  task automatic send(input logic [2:0] f, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [2:0] wi,
                      input logic [DW-1:0] wd);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_funct = f;
    cmd_a = a;
    cmd_b = b;
    cmd_widx = wi;
    cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout cmd_ready=%0b required=1", cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || step_count !== '0 || step_pulse !== 1'b0 ||
        sat !== 1'b0 || err_illegal !== 1'b0 || ex_a !== '0 || ex_b !== '0 ||
        theta1_1 !== '0 || alpha2 !== '0) begin
      errors++;
      $display("FAIL reset_state ready=%0b count=%0d pulse=%0b sat=%0b err=%0b ex_a=%0d required ready=1 rest 0",
               cmd_ready, step_count, step_pulse, sat, err_illegal, ex_a);
    end
    rst = 1'b0;
  endtask

  task automatic test_weights();
    logic [DW-1:0] w;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(3'd2, '0, '0, 3'(i), DW'(11 + i));
      case (i)
        0: w = theta1_1;
        1: w = theta1_2;
        2: w = theta2_1;
        3: w = theta2_2;
        4: w = alpha1;
        default: w = alpha2;
      endcase
      checks++;
      if (w !== DW'(11 + i) || cmd_ready !== 1'b1 || err_illegal !== 1'b0) begin
        errors++;
        $display("FAIL weight_write idx=%0d got=%0d ready=%0b err=%0b required=%0d ready=1 err=0",
                 i, w, cmd_ready, err_illegal, 11 + i);
      end
    end
  endtask

  task automatic test_sample();
    do_reset();
    ex_step = 1'b0;
    send(3'd1, 10'd100, 10'd200, '0, '0);  // returns at E0+#1
    ex_step = 1'b1;
    checks++;
    if (ex_a !== 10'd100 || ex_b !== 10'd200 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL sample_load ex_a=%0d ex_b=%0d ready=%0b required 100 200 0", ex_a, ex_b, cmd_ready);
    end
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (cmd_ready !== 1'b0 || step_count !== '0 || step_pulse !== 1'b0) begin
        errors++;
        $display("FAIL sample_wait E0+%0d ready=%0b count=%0d pulse=%0b required 0 0 0",
                 k, cmd_ready, step_count, step_pulse);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || step_count !== 10'd1 || step_pulse !== 1'b1) begin
      errors++;
      $display("FAIL sample_capt ready=%0b count=%0d pulse=%0b required 1 1 1",
               cmd_ready, step_count, step_pulse);
    end
    @(posedge clk);
    #1;
    checks++;
    if (step_pulse !== 1'b0 || step_count !== 10'd1) begin
      errors++;
      $display("FAIL sample_pulse_end pulse=%0b count=%0d required 0 1", step_pulse, step_count);
    end
  endtask

  task automatic test_hold_off();
    do_reset();
    ex_step = 1'b0;
    send(3'd1, 10'd5, 10'd6, '0, '0);
    // Weight write offered during WAIT, held valid until taken.
    cmd_valid = 1'b1;
    cmd_funct = 3'd2;
    cmd_widx = 3'd4;
    cmd_wdata = 10'd77;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (alpha1 !== '0 || cmd_ready !== (k == 3)) begin
        errors++;
        $display("FAIL hold_off E0+%0d alpha1=%0d ready=%0b required 0 %0d", k, alpha1, cmd_ready, (k == 3));
      end
    end
    checks++;
    if (step_count !== '0 || step_pulse !== 1'b0) begin
      errors++;
      $display("FAIL no_step count=%0d pulse=%0b required 0 0", step_count, step_pulse);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    checks++;
    if (alpha1 !== 10'd77 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL held_write alpha1=%0d ready=%0b required 77 1", alpha1, cmd_ready);
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] e;
    logic [2:0] exp_pulse;
    logic [2:0] exp_sat;
    do_reset();
    ex_step = 1'b1;
    for (int i = 0; i < 1022; i++) send(3'd1, DW'(i), '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (step_count !== 10'd1022 || sat !== 1'b0) begin
      errors++;
      $display("FAIL preload count=%0d sat=%0b required 1022 0", step_count, sat);
    end
    exp_q.push_back(10'd1023);
    exp_q.push_back(10'd1023);
    exp_q.push_back(10'd1023);
    exp_pulse = 3'b001;
    exp_sat   = 3'b110;
    for (int k = 0; k < 3; k++) begin
      send(3'd1, '0, '0, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (step_count !== e || step_pulse !== exp_pulse[k] || sat !== exp_sat[k]) begin
        errors++;
        $display("FAIL saturate sample=%0d count=%0d pulse=%0b sat=%0b required %0d %0b %0b",
                 k, step_count, step_pulse, sat, e, exp_pulse[k], exp_sat[k]);
      end
    end
    send(3'd0, '0, '0, '0, '0);
    checks++;
    if (step_count !== '0 || sat !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear count=%0d sat=%0b ready=%0b required 0 0 1", step_count, sat, cmd_ready);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    ex_step = 1'b0;
    send(3'd2, '0, '0, 3'd0, 10'd5);
    send(3'd1, 10'd3, 10'd4, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    send(3'd5, 10'd9, 10'd9, 3'd0, 10'd9);
    checks++;
    if (err_illegal !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_funct err=%0b ready=%0b required 1 1", err_illegal, cmd_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err_illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse_len err=%0b required 0", err_illegal);
    end
    send(3'd2, '0, '0, 3'd7, 10'd99);
    checks++;
    if (err_illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_widx err=%0b required 1", err_illegal);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err_illegal !== 1'b0 || theta1_1 !== 10'd5 || theta1_2 !== '0 || alpha2 !== '0 ||
        ex_a !== 10'd3 || ex_b !== 10'd4 || step_count !== '0) begin
      errors++;
      $display("FAIL illegal_no_change err=%0b t11=%0d t12=%0d a2=%0d ex_a=%0d ex_b=%0d count=%0d required 0 5 0 0 3 4 0",
               err_illegal, theta1_1, theta1_2, alpha2, ex_a, ex_b, step_count);
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    send(3'd2, '0, '0, 3'd2, 10'd9);
    ex_step = 1'b1;
    send(3'd1, 10'd1, 10'd2, '0, '0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || step_count !== '0 || theta2_1 !== '0 || ex_a !== '0) begin
      errors++;
      $display("FAIL reset_wait ready=%0b count=%0d t21=%0d ex_a=%0d required 1 0 0 0",
               cmd_ready, step_count, theta2_1, ex_a);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (step_pulse !== 1'b0 || step_count !== '0) begin
        errors++;
        $display("FAIL reset_abandon cyc=%0d pulse=%0b count=%0d required 0 0", k, step_pulse, step_count);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    int cyc;
    int acc_cyc[2];
    logic r;
    do_reset();
    ex_step = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_funct = 3'd1;
    cmd_a = 10'd7;
    cmd_b = 10'd8;
    acc = 0;
    cyc = 0;
    while (acc < 2 && cyc < 20) begin
      r = cmd_ready;
      @(posedge clk);
      if (r) begin
        acc_cyc[acc] = cyc;
        acc++;
      end
      cyc++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (acc !== 2 || acc_cyc[1] - acc_cyc[0] !== 4 || step_count !== 10'd2) begin
      errors++;
      $display("FAIL back_to_back accepts=%0d spacing=%0d count=%0d required 2 4 2",
               acc, acc_cyc[1] - acc_cyc[0], step_count);
    end
  endtask

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_funct = '0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_widx = '0;
    cmd_wdata = '0;
    ex_step = 1'b0;
    test_reset();
    test_weights();
    test_sample();
    test_hold_off();
    test_saturation();
    test_illegal();
    test_reset_in_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
